// File: rtl/layer_sched_pkg.sv
// Shared types and helpers for the layer scheduler: FSM state encoding and
// counter-width helper.
package layer_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // A counter over x values needs clog2(x) bits, but never fewer than one.
  function automatic int width_of(input int x);
    return (x < 2) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/layer_scheduler_counter.sv
// Modulo-M up counter with synchronous clear and enable; wrap_o flags the
// terminal count M-1 so the owner can chain the next counter.
module mod_counter
  import layer_sched_pkg::*;
#(
  parameter  int M = 2,
  localparam int W = width_of(M)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign wrap_o = (cnt_q == W'(M - 1));
  assign cnt_d  = wrap_o ? '0 : cnt_q + 1'b1;
  assign cnt_o  = cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/layer_scheduler.sv
// Walks one shared dot-product datapath through N neurons x Q samples x D
// features, handing each accumulated result to a valid/ready sink.
module layer_scheduler
  import layer_sched_pkg::*;
#(
  parameter  int N  = 2,
  parameter  int Q  = 3,
  parameter  int D  = 4,
  localparam int NW = width_of(N),
  localparam int QW = width_of(Q),
  localparam int DW = width_of(D),
  localparam int RW = width_of(N * Q)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st,
  input  logic          abort,
  output logic          busy,
  output logic          clear_acc,
  output logic          mem_rd,
  output logic [QW-1:0] addr_x,
  output logic [NW-1:0] addr_w,
  output logic [DW-1:0] index_d,
  output logic          acc_en,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [RW-1:0] res_addr,
  output logic          done
);

  state_t        state_q, state_d;
  logic          acc_en_q, acc_en_d;
  logic [NW-1:0] n_q;
  logic [QW-1:0] q_q;
  logic [DW-1:0] k_q;
  logic          n_wrap, q_wrap, k_wrap;
  logic          cnt_clr, hs;

  // Counters are forced to zero whenever the scheduler is idle or aborted.
  assign cnt_clr = abort || (state_q == S_IDLE);
  assign hs      = (state_q == S_WRITE) && res_ready;

  mod_counter #(.M(D)) u_k (
    .clk(clk), .rst(rst), .clr_i(cnt_clr), .en_i(state_q == S_RUN),
    .cnt_o(k_q), .wrap_o(k_wrap)
  );

  mod_counter #(.M(Q)) u_q (
    .clk(clk), .rst(rst), .clr_i(cnt_clr), .en_i(hs),
    .cnt_o(q_q), .wrap_o(q_wrap)
  );

  mod_counter #(.M(N)) u_n (
    .clk(clk), .rst(rst), .clr_i(cnt_clr), .en_i(hs && q_wrap),
    .cnt_o(n_q), .wrap_o(n_wrap)
  );

  // Memory read latency is one cycle, so accumulate trails the read strobe.
  assign acc_en_d = (state_q == S_RUN) && !abort;
  assign acc_en   = acc_en_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_en_q <= acc_en_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    busy      = (state_q != S_IDLE);
    clear_acc = 1'b0;
    mem_rd    = 1'b0;
    addr_x    = '0;
    addr_w    = '0;
    index_d   = '0;
    res_valid = 1'b0;
    res_addr  = '0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (st) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        clear_acc = 1'b1;
        state_d   = S_RUN;
      end
      S_RUN: begin
        mem_rd  = 1'b1;
        addr_x  = q_q;
        addr_w  = n_q;
        index_d = k_q;
        if (k_wrap) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        state_d = S_WRITE;
      end
      S_WRITE: begin
        res_valid = 1'b1;
        res_addr  = RW'(RW'(n_q) * RW'(Q) + RW'(q_q));
        if (res_ready) state_d = (q_wrap && n_wrap) ? S_DONE : S_CLEAR;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

endmodule

// File: tb/tb_layer_scheduler.sv
// Bench for layer_scheduler: a flat pair-index/phase reference model checked
// every cycle, plus directed latency, ordering, stall, abort and reset checks.
module tb_layer_scheduler;

  localparam int N  = 2;
  localparam int Q  = 3;
  localparam int D  = 4;
  localparam int NW = 1;
  localparam int QW = 2;
  localparam int DW = 2;
  localparam int RW = 3;
  localparam int LAYER_CYC = N * Q * (D + 3) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, st, abort, res_ready;
  logic          busy, clear_acc, mem_rd, acc_en, res_valid, done;
  logic [QW-1:0] addr_x;
  logic [NW-1:0] addr_w;
  logic [DW-1:0] index_d;
  logic [RW-1:0] res_addr;

  logic d_st, d_abort, d_ready;
  logic d_busy, d_clear, d_mem, d_acc, d_valid, d_done;
  logic d_addr_x, d_addr_w, d_index, d_res_addr;

  layer_scheduler #(.N(N), .Q(Q), .D(D)) dut (
    .clk(clk), .rst(rst), .st(st), .abort(abort), .busy(busy),
    .clear_acc(clear_acc), .mem_rd(mem_rd), .addr_x(addr_x), .addr_w(addr_w),
    .index_d(index_d), .acc_en(acc_en), .res_valid(res_valid),
    .res_ready(res_ready), .res_addr(res_addr), .done(done)
  );

  layer_scheduler #(.N(1), .Q(1), .D(1)) dut_deg (
    .clk(clk), .rst(rst), .st(d_st), .abort(d_abort), .busy(d_busy),
    .clear_acc(d_clear), .mem_rd(d_mem), .addr_x(d_addr_x), .addr_w(d_addr_w),
    .index_d(d_index), .acc_en(d_acc), .res_valid(d_valid),
    .res_ready(d_ready), .res_addr(d_res_addr), .done(d_done)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: flat result index p = n*Q+q and phase t within a result
  // (0 clear, 1..D reads, D+1 drain, D+2 write).
  bit m_active, m_done, m_acc;
  int m_p, m_t;

  int got[$];
  int done_cyc, saw_done, start_cyc;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic timeout(input string tag);
    total++;
    bad++;
    $error("FAIL %s: observed=timeout expected=completion (cycle %0d)", tag, cyc);
  endtask

  function automatic bit m_mem();
    return m_active && m_t >= 1 && m_t <= D;
  endfunction

  task automatic check_all();
    bit mem;
    bit valid;
    mem   = m_mem();
    valid = m_active && m_t == D + 2;
    chk("busy",      int'(busy),      int'(m_active || m_done));
    chk("clear_acc", int'(clear_acc), int'(m_active && m_t == 0));
    chk("mem_rd",    int'(mem_rd),    int'(mem));
    chk("acc_en",    int'(acc_en),    int'(m_acc));
    chk("res_valid", int'(res_valid), int'(valid));
    chk("done",      int'(done),      int'(m_done));
    if (mem) begin
      chk("addr_x",  int'(addr_x),  m_p % Q);
      chk("addr_w",  int'(addr_w),  m_p / Q);
      chk("index_d", int'(index_d), m_t - 1);
    end
    if (valid) chk("res_addr", int'(res_addr), m_p);
  endtask

  // One clock: log handshakes seen with the current inputs, advance the
  // model, then compare on the falling edge.
  task automatic step();
    bit prev_mem;
    if (res_valid && res_ready) got.push_back(int'(res_addr));
    prev_mem = m_mem();
    if (rst || abort) begin
      m_active = 0; m_done = 0; m_acc = 0; m_p = 0; m_t = 0;
    end else begin
      m_acc = prev_mem;
      if (m_done) begin
        m_done = 0;
      end else if (!m_active) begin
        if (st) begin m_active = 1; m_p = 0; m_t = 0; end
      end else if (m_t < D + 2) begin
        m_t++;
      end else if (res_ready) begin
        if (m_p == N * Q - 1) begin m_active = 0; m_done = 1; m_p = 0; m_t = 0; end
        else begin m_p++; m_t = 0; end
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_all();
    if (done) begin done_cyc = cyc; saw_done++; end
  endtask

  // mode 0: sink always ready; 1: stall 5 cycles at result n=0,q=1; 2: random ready
  task automatic run_until_done(input int budget, input int mode);
    int stall;
    int i;
    bit stalled;
    stall = 0;
    for (i = 0; i < budget; i++) begin
      stalled = 0;
      if (mode == 1 && m_active && m_t == D + 2 && m_p == 1 && stall < 5) begin
        res_ready = 0; stall++; stalled = 1;
      end else if (mode == 2) begin
        res_ready = ($urandom % 4) != 0;
      end else begin
        res_ready = 1;
      end
      step();
      if (stalled) begin
        chk("stall_valid", int'(res_valid), 1);
        chk("stall_addr",  int'(res_addr),  1);
        chk("stall_rd",    int'(mem_rd || clear_acc), 0);
      end
      if (saw_done != 0) break;
    end
    if (i == budget) timeout("run_done");
    if (mode == 1) chk("stall_cycles", stall, 5);
  endtask

  task automatic start_pulse();
    got.delete();
    saw_done  = 0;
    start_cyc = cyc;
    st = 1;
    step();
    st = 0;
  endtask

  task automatic check_results(input string tag);
    chk({tag, "_count"}, got.size(), N * Q);
    foreach (got[i]) chk({tag, "_order"}, got[i], i);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  logic [5:0] deg_exp [6] = '{6'b110000, 6'b101000, 6'b100100,
                              6'b100010, 6'b100001, 6'b000000};

  initial begin
    int guard;
    int deg_done;
    logic [5:0] dv;
    rst = 1; st = 0; abort = 0; res_ready = 0;
    d_st = 0; d_abort = 0; d_ready = 1;
    m_active = 0; m_done = 0; m_acc = 0; m_p = 0; m_t = 0;
    done_cyc = 0; saw_done = 0; start_cyc = 0;
    idle_cycles(2);
    rst = 0;
    idle_cycles(2);
    chk("reset_busy", int'(busy), 0);

    // Basic layer with an always-ready sink.
    start_pulse();
    run_until_done(200, 0);
    chk("basic_latency", done_cyc - start_cyc, LAYER_CYC);
    check_results("basic");
    idle_cycles(3);

    // Backpressure at result 1.
    start_pulse();
    run_until_done(200, 1);
    chk("stall_latency", done_cyc - start_cyc, LAYER_CYC + 5);
    check_results("stall");
    idle_cycles(2);

    // Abort mid-RUN at n=1, q=0, k=2.
    start_pulse();
    res_ready = 1;
    for (guard = 0; guard < 100 && !(m_p == 3 && m_t == 3); guard++) step();
    if (guard == 100) timeout("abort_reach");
    chk("abort_pre_idx", int'(index_d), 2);
    abort = 1;
    step();
    abort = 0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_outs", int'({clear_acc, mem_rd, acc_en, res_valid, done}), 0);
    idle_cycles(8);
    chk("abort_no_done", saw_done, 0);
    start_pulse();
    run_until_done(200, 0);
    chk("restart_latency", done_cyc - start_cyc, LAYER_CYC);
    check_results("restart");
    idle_cycles(2);

    // Abort beats start in IDLE.
    st = 1; abort = 1;
    step();
    st = 0; abort = 0;
    chk("abort_beats_st", int'(busy), 0);

    // st held high through two back-to-back runs, second starts right after done.
    got.delete(); saw_done = 0; start_cyc = cyc;
    st = 1;
    run_until_done(200, 0);
    chk("held_latency1", done_cyc - start_cyc, LAYER_CYC);
    check_results("held1");
    got.delete(); saw_done = 0; start_cyc = cyc + 1;
    run_until_done(200, 0);
    st = 0;
    chk("held_latency2", done_cyc - start_cyc, LAYER_CYC);
    check_results("held2");
    idle_cycles(2);

    // Start pulses sprinkled through RUN are ignored.
    start_pulse();
    for (guard = 0; guard < 300 && saw_done == 0; guard++) begin
      res_ready = 1;
      st = m_active && m_t >= 1 && m_t <= D && (($urandom % 2) != 0);
      step();
    end
    st = 0;
    if (guard == 300) timeout("pulse_run");
    chk("pulse_latency", done_cyc - start_cyc, LAYER_CYC);
    check_results("pulse");
    idle_cycles(2);

    // Reset while WRITE is stalled.
    start_pulse();
    res_ready = 0;
    for (guard = 0; guard < 50 && !(m_active && m_t == D + 2); guard++) step();
    if (guard == 50) timeout("write_reach");
    idle_cycles(2);
    chk("pre_rst_valid", int'(res_valid), 1);
    rst = 1;
    step();
    rst = 0;
    chk("rst_busy",  int'(busy), 0);
    chk("rst_valid", int'(res_valid), 0);
    res_ready = 1;
    idle_cycles(2);

    // Reset and abort together mid-run.
    start_pulse();
    idle_cycles(3);
    rst = 1; abort = 1;
    step();
    rst = 0; abort = 0;
    chk("rst_abort_busy", int'(busy), 0);
    chk("rst_abort_outs", int'({clear_acc, mem_rd, acc_en, res_valid, done}), 0);
    idle_cycles(2);

    // Randomised traffic: ready, start and rare aborts all from $urandom.
    for (int i = 0; i < 1500; i++) begin
      res_ready = ($urandom % 4) != 0;
      st        = ($urandom % 8) == 0;
      abort     = ($urandom % 97) == 0;
      step();
    end
    st = 0; abort = 0; res_ready = 1;
    idle_cycles(60);
    chk("random_settle", int'(busy), 0);

    // Degenerate N=Q=D=1 instance.
    d_st = 1;
    step();
    d_st = 0;
    deg_done = 0;
    for (int c = 0; c < 6; c++) begin
      dv = {d_busy, d_clear, d_mem, d_acc, d_valid, d_done};
      chk("deg_seq", int'(dv), int'(deg_exp[c]));
      if (d_valid) chk("deg_res_addr", int'(d_res_addr), 0);
      if (d_done) deg_done = c + 1;
      step();
    end
    chk("deg_done_cycle", deg_done, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
